// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer mode scheduler.
//  - state_t    : scheduler FSM encoding
//  - MODE_*     : scale-mode codes carried on sw_sel / active_mode
//  - *_DEF      : default timing parameters
//  - cnt_width  : bits needed to hold a count value up to max_val
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    WAIT_VS = 3'd2,
    RESTART = 3'd3,
    COPY    = 3'd4,
    HPS     = 3'd5
  } state_t;

  // sw_sel[1:0] selects the scaling operator, sw_sel[3] selects factor 4
  localparam logic [3:0] MODE_REPL   = 4'b0000;
  localparam logic [3:0] MODE_DECIM  = 4'b0001;
  localparam logic [3:0] MODE_NN     = 4'b0010;
  localparam logic [3:0] MODE_AVG    = 4'b0011;
  localparam int         MODE_X4_BIT = 3;

  localparam int SETTLE_CYC_DEF  = 1024;
  localparam int RST_CYC_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 1048576;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fb_stable_detect.sv
// Switch debouncer for the mode scheduler.
// Watches sw_sel while run is high and raises stable once the value has
// been unchanged for SETTLE_CYC consecutive cycles.
// Ports:
//  clk     in  pixel clock
//  reset   in  synchronous, active-high
//  run     in  high while the scheduler is settling; low holds the counter at 0
//  sw_sel  in  synchronised mode switches
//  stable  out high in the cycle the settle count completes with no change
module fb_stable_detect
  import fb_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] sw_sel,
  output logic       stable
);

  localparam int              W    = cnt_width(SETTLE_CYC);
  localparam logic [W-1:0]    LAST = W'(SETTLE_CYC - 1);

  logic [3:0]   sw_prev;
  logic [W-1:0] cnt;
  logic         changed;

  assign changed = (sw_sel != sw_prev);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_prev <= MODE_REPL;
      cnt     <= '0;
    end else begin
      sw_prev <= sw_sel;
      // any change restarts the window; the count saturates at LAST
      if (!run || changed)
        cnt <= '0;
      else if (cnt != LAST)
        cnt <= cnt + 1'b1;
    end
  end

  assign stable = run && !changed && (cnt == LAST);

endmodule

// File: rtl/fb_mode_scheduler.sv
// Framebuffer mode scheduler (clk_vga domain).
// Debounces mode switches, commits a new mode at a frame boundary, restarts
// the ROM->framebuffer copier, blanks the display while the framebuffer is
// rewritten, and arbitrates the shared ROM between the copier and HPS.
// Ports:
//  clk          in   pixel clock
//  reset        in   synchronous, active-high
//  sw_sel       in   [3:0] synchronised mode switches
//  frame_start  in   one-cycle pulse at first blanking line
//  copy_done    in   copier finished (level, cleared by copier_rst)
//  hps_req      in   HPS wants the source ROM (level)
//  active_mode  out  [3:0] committed mode
//  copier_rst   out  copier restart, active high
//  display_en   out  1 = show framebuffer, 0 = black
//  hps_grant    out  HPS owns the ROM
//  busy         out  high in every state except IDLE
//  err_timeout  out  sticky copy-overrun flag
// All outputs are registered.
module fb_mode_scheduler
  import fb_pkg::*;
#(
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int RST_CYC     = RST_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_sel,
  input  logic       frame_start,
  input  logic       copy_done,
  input  logic       hps_req,
  output logic [3:0] active_mode,
  output logic       copier_rst,
  output logic       display_en,
  output logic       hps_grant,
  output logic       busy,
  output logic       err_timeout
);

  // one down-counter is shared by RESTART and COPY, sized for the timeout
  localparam int               CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       mode_nx;
  logic             rst_nx, disp_nx, err_nx;
  logic             stable;

  fb_stable_detect #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_stable (
    .clk    (clk),
    .reset  (reset),
    .run    (state == SETTLE),
    .sw_sel (sw_sel),
    .stable (stable)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // power-up goes straight to RESTART so mode 0 is copied once
      state       <= RESTART;
      cnt         <= RST_LOAD;
      active_mode <= MODE_REPL;
      copier_rst  <= 1'b1;
      display_en  <= 1'b0;
      hps_grant   <= 1'b0;
      busy        <= 1'b1;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      active_mode <= mode_nx;
      copier_rst  <= rst_nx;
      display_en  <= disp_nx;
      hps_grant   <= (state_nx == HPS);
      busy        <= (state_nx != IDLE);
      err_timeout <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mode_nx  = active_mode;
    rst_nx   = copier_rst;
    disp_nx  = display_en;
    err_nx   = err_timeout;

    case (state)
      IDLE: begin
        // hps_req wins over a pending switch change
        if (hps_req)
          state_nx = HPS;
        else if (sw_sel != active_mode)
          state_nx = SETTLE;
      end

      SETTLE: begin
        if (sw_sel == active_mode)
          state_nx = IDLE;
        else if (stable)
          state_nx = WAIT_VS;
      end

      WAIT_VS: begin
        // frame_start is only meaningful here
        if (frame_start) begin
          mode_nx  = sw_sel;
          state_nx = RESTART;
          cnt_nx   = RST_LOAD;
        end
      end

      RESTART: begin
        if (cnt == '0) begin
          state_nx = COPY;
          cnt_nx   = TO_LOAD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      COPY: begin
        // copy_done beats abort beats timeout; hps_req waits for IDLE
        if (copy_done) begin
          state_nx = IDLE;
        end else if (sw_sel != active_mode) begin
          state_nx = SETTLE;
          rst_nx   = 1'b1;
        end else if (cnt == '0) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      HPS: begin
        if (!hps_req) begin
          state_nx = RESTART;
          cnt_nx   = RST_LOAD;
        end
      end

      default: state_nx = IDLE;
    endcase

    // copier_rst / display_en follow the destination state; SETTLE and
    // WAIT_VS keep whatever was there, so a settle started from IDLE keeps
    // the picture up while one started by an aborted copy stays blanked
    // with the copier parked in reset.
    case (state_nx)
      RESTART, HPS: begin
        rst_nx  = 1'b1;
        disp_nx = 1'b0;
      end
      COPY: begin
        rst_nx  = 1'b0;
        disp_nx = 1'b0;
      end
      IDLE: begin
        rst_nx  = 1'b0;
        disp_nx = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fb_mode_scheduler.sv
module tb_fb_mode_scheduler;

  localparam int SETTLE = 16;
  localparam int RSTC   = 4;
  localparam int TO     = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_sel;
  logic       frame_start;
  logic       copy_done;
  logic       hps_req;
  logic [3:0] active_mode;
  logic       copier_rst;
  logic       display_en;
  logic       hps_grant;
  logic       busy;
  logic       err_timeout;

  fb_mode_scheduler #(
    .SETTLE_CYC  (SETTLE),
    .RST_CYC     (RSTC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_sel      (sw_sel),
    .frame_start (frame_start),
    .copy_done   (copy_done),
    .hps_req     (hps_req),
    .active_mode (active_mode),
    .copier_rst  (copier_rst),
    .display_en  (display_en),
    .hps_grant   (hps_grant),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_mode = 4'b0000;
  logic [3:0] cur_mode  = 4'b0000;

  typedef struct {
    logic [3:0] sw;
    int         fs_wait;
    int         copy_len;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every committed mode must match the next queued expectation
  always @(negedge clk) begin : sb
    logic [3:0] e;
    if (reset === 1'b0 && active_mode !== last_mode) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %0h want no change from %0h", active_mode, last_mode);
      end else begin
        e = exp_q.pop_front();
        if (active_mode !== e) begin
          bad++;
          $display("FAIL sb_mode: got %0h want %0h", active_mode, e);
        end
      end
      last_mode = active_mode;
    end
  end

  task automatic count_rst(output int n);
    n = 0;
    while (copier_rst === 1'b1 && n < 20) begin
      n++;
      tick;
    end
  endtask

  task automatic frame_pulse(input logic [3:0] m);
    frame_start = 1'b1;
    exp_q.push_back(m);
    tick;
    frame_start = 1'b0;
  endtask

  task automatic finish_copy(input int len);
    repeat (len - 1) tick;
    copy_done = 1'b1;
    tick;
    copy_done = 1'b0;
  endtask

  // settle into WAIT_VS from IDLE (picture must stay up), commit, restart, copy
  task automatic do_mode(input vec_t v);
    int   n;
    logic ok;
    sw_sel = v.sw;
    ok = 1'b1;
    repeat (SETTLE + 1 + v.fs_wait) begin
      tick;
      if (copier_rst !== 1'b0 || display_en !== 1'b1) ok = 1'b0;
    end
    chk("settle_quiet", ok, 1);
    chk("waitvs_busy", busy, 1);
    chk("mode_before_vs", active_mode, cur_mode);
    frame_pulse(v.sw);
    chk("mode_after_vs", active_mode, v.sw);
    cur_mode = v.sw;
    count_rst(n);
    chk("rst_len", n, RSTC);
    chk("copy_disp", display_en, 0);
    finish_copy(v.copy_len);
    chk("done_disp", display_en, 1);
    chk("done_busy", busy, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   n;
    logic ok;
    vecs[0] = '{4'b1000, 200, 30};
    vecs[1] = '{4'b0010, 3, 20};
    vecs[2] = '{4'b0011, 0, 40};
    vecs[3] = '{4'b1001, 7, 10};
    vecs[4] = '{4'b0000, 1, 25};

    reset = 1'b1; sw_sel = 4'b0000; frame_start = 1'b0; copy_done = 1'b0; hps_req = 1'b0;
    repeat (3) tick;
    chk("rst_mode", active_mode, 0);
    chk("rst_crst", copier_rst, 1);
    chk("rst_disp", display_en, 0);
    chk("rst_grant", hps_grant, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err_timeout, 0);
    reset = 1'b0;

    // power-up copy of mode 0, done 50 cycles after release
    count_rst(n);
    chk("pwr_rst_len", n, RSTC);
    chk("pwr_copy_disp", display_en, 0);
    chk("pwr_copy_busy", busy, 1);
    finish_copy(50 - RSTC);
    chk("pwr_done_disp", display_en, 1);
    chk("pwr_done_busy", busy, 0);
    chk("pwr_mode", active_mode, 0);
    chk("pwr_err", err_timeout, 0);

    // short glitch: back to IDLE, no restart, mode unchanged
    sw_sel = 4'b0010;
    ok = 1'b1;
    repeat (SETTLE / 2) begin
      tick;
      if (copier_rst !== 1'b0 || display_en !== 1'b1) ok = 1'b0;
    end
    chk("glitch_quiet", ok, 1);
    chk("glitch_busy", busy, 1);
    sw_sel = 4'b0000;
    tick;
    chk("glitch_idle", busy, 0);
    chk("glitch_mode", active_mode, 0);

    foreach (vecs[i]) do_mode(vecs[i]);

    // abort mid-copy: copier reset at once, display stays black, new mode copied
    sw_sel = 4'b0011;
    repeat (SETTLE + 3) tick;
    frame_pulse(4'b0011);
    cur_mode = 4'b0011;
    count_rst(n);
    repeat (10) tick;
    sw_sel = 4'b0001;
    tick;
    chk("abort_crst", copier_rst, 1);
    chk("abort_disp", display_en, 0);
    chk("abort_mode", active_mode, 4'b0011);
    ok = 1'b1;
    repeat (SETTLE + 3) begin
      tick;
      if (display_en !== 1'b0 || copier_rst !== 1'b1) ok = 1'b0;
    end
    chk("abort_blank", ok, 1);
    frame_pulse(4'b0001);
    cur_mode = 4'b0001;
    chk("abort_newmode", active_mode, 4'b0001);
    count_rst(n);
    chk("abort_rst_len", n, RSTC);
    finish_copy(15);
    chk("abort_done_busy", busy, 0);

    // hps_req mid-copy: grant only after the copy completes
    sw_sel = 4'b1011;
    repeat (SETTLE + 3) tick;
    frame_pulse(4'b1011);
    cur_mode = 4'b1011;
    count_rst(n);
    repeat (5) tick;
    hps_req = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      tick;
      if (hps_grant !== 1'b0 || copier_rst !== 1'b0) ok = 1'b0;
    end
    chk("hps_no_grant_mid_copy", ok, 1);
    copy_done = 1'b1;
    tick;
    copy_done = 1'b0;
    chk("hps_idle_grant", hps_grant, 0);
    chk("hps_idle_busy", busy, 0);
    tick;
    chk("hps_grant", hps_grant, 1);
    chk("hps_crst", copier_rst, 1);
    chk("hps_disp", display_en, 0);
    repeat (5) tick;
    hps_req = 1'b0;
    tick;
    chk("hps_release", hps_grant, 0);
    chk("hps_recopy_crst", copier_rst, 1);
    chk("hps_same_mode", active_mode, 4'b1011);
    count_rst(n);
    chk("hps_rst_len", n, RSTC);
    finish_copy(10);
    chk("hps_done_busy", busy, 0);

    // in IDLE, hps_req beats a simultaneous switch change
    sw_sel = 4'b0100;
    hps_req = 1'b1;
    tick;
    chk("prio_grant", hps_grant, 1);
    sw_sel = 4'b1011;
    hps_req = 1'b0;
    tick;
    chk("prio_release", hps_grant, 0);
    count_rst(n);
    chk("prio_rst_len", n, RSTC);
    finish_copy(5);
    chk("prio_mode", active_mode, 4'b1011);
    chk("prio_err", err_timeout, 0);

    // copy never completes: timeout after exactly TO cycles of COPY
    sw_sel = 4'b0110;
    repeat (SETTLE + 3) tick;
    frame_pulse(4'b0110);
    cur_mode = 4'b0110;
    count_rst(n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick;
    end
    chk("to_len", n, TO);
    chk("to_err", err_timeout, 1);
    chk("to_disp", display_en, 1);
    chk("to_busy", busy, 0);
    repeat (5) tick;
    chk("to_err_sticky", err_timeout, 1);
    do_mode('{4'b0010, 2, 12});
    chk("to_err_after_copy", err_timeout, 1);

    repeat (3) tick;
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
